// File: rtl/mem_access_if.sv
// Bundles the request/response handshake and the data-memory port of mem_access_unit.
// slave = the access unit itself, master = the MEM stage plus memory side driving it.
interface mem_access_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_size, mem_signed, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_size, mem_signed, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits misaligned half/word accesses into little-endian byte beats.
// Define MISALIGN_TRAP_EN to trap misaligned requests (resp_err) instead of splitting them.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT} state_t;

  state_t            state, state_next;
  logic [1:0]        beat, last_beat, next_beat;
  logic              op_write, op_signed, err_pending;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata, load_buf, lanes;
  logic              mem_read, mem_write;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              accept, misaligned;

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                     input logic [1:0] size, input logic sgn);
    logic [DATA_W-1:0] r;
    case (size)
      2'b00:   r = raw;
      2'b01:   r = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
      default: r = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
    endcase
    return r;
  endfunction

  assign accept     = bus.req_valid && (state == IDLE);
  assign misaligned = ((bus.req_size == 2'b00) && (bus.req_addr[1:0] != 2'b00)) ||
                      ((bus.req_size == 2'b01) && bus.req_addr[0]);
  assign next_beat  = beat + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MISALIGN_TRAP_EN
          state_next = ACCESS;
`else
          state_next = misaligned ? SPLIT : ACCESS;
`endif
        end
      end
      ACCESS:  state_next = IDLE;
      SPLIT:   if (beat == last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The beat being read this cycle lands in its byte lane; earlier lanes come from load_buf.
  always_comb begin
    lanes = load_buf;
    lanes[8*beat +: 8] = bus.mem_rdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0; last_beat <= '0;
      op_write <= 1'b0; op_signed <= 1'b0; op_size <= '0; op_addr <= '0; op_wdata <= '0;
      load_buf <= '0; err_pending <= 1'b0;
      mem_read <= 1'b0; mem_write <= 1'b0; mem_size <= '0; mem_addr <= '0; mem_wdata <= '0;
      resp_valid <= 1'b0; resp_err <= 1'b0; resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write  <= bus.req_write;
            op_signed <= bus.req_signed;
            op_size   <= bus.req_size;
            op_addr   <= bus.req_addr;
            op_wdata  <= bus.req_wdata;
            beat      <= '0;
            load_buf  <= '0;
            if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
              err_pending <= 1'b1;
`else
              mem_read  <= ~bus.req_write;
              mem_write <= bus.req_write;
              mem_size  <= 2'b10;
              mem_addr  <= bus.req_addr;
              mem_wdata <= {{(DATA_W-8){1'b0}}, bus.req_wdata[7:0]};
              last_beat <= (bus.req_size == 2'b00) ? 2'd3 : 2'd1;
`endif
            end else begin
              mem_read  <= ~bus.req_write;
              mem_write <= bus.req_write;
              mem_size  <= (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
              mem_addr  <= bus.req_addr;
              mem_wdata <= bus.req_wdata;
            end
          end
        end
        ACCESS: begin
          mem_read <= 1'b0; mem_write <= 1'b0; mem_size <= '0; mem_addr <= '0; mem_wdata <= '0;
          resp_valid  <= 1'b1;
          resp_err    <= err_pending;
          resp_rdata  <= (op_write || err_pending) ? '0 : extend_load(bus.mem_rdata, op_size, op_signed);
          err_pending <= 1'b0;
        end
        SPLIT: begin
          load_buf <= lanes;
          if (beat == last_beat) begin
            mem_read <= 1'b0; mem_write <= 1'b0; mem_size <= '0; mem_addr <= '0; mem_wdata <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= op_write ? '0 : extend_load(lanes, op_size, op_signed);
          end else begin
            beat      <= next_beat;
            mem_addr  <= op_addr + ADDR_W'(next_beat);
            mem_wdata <= {{(DATA_W-8){1'b0}}, op_wdata[8*next_beat +: 8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_size   = mem_size;
  assign bus.mem_signed = 1'b0;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-byte little-endian memory model.
// Builds the trap-mode scenarios instead of the split ones when MISALIGN_TRAP_EN is defined.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_access_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Memory model: combinational reads, writes on the falling edge, pokes share the same process.
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] a0, a1, a2, a3;

  assign a0 = bus.mem_addr;
  assign a1 = bus.mem_addr + 8'd1;
  assign a2 = bus.mem_addr + 8'd2;
  assign a3 = bus.mem_addr + 8'd3;

  always_comb begin
    case (bus.mem_size)
      2'b00:   bus.mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      2'b01:   bus.mem_rdata = {16'h0, mem[a1], mem[a0]};
      default: bus.mem_rdata = {24'h0, mem[a0]};
    endcase
  end

  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_write) begin
      mem[a0] <= bus.mem_wdata[7:0];
      if (bus.mem_size != 2'b10 && bus.mem_size != 2'b11) mem[a1] <= bus.mem_wdata[15:8];
      if (bus.mem_size == 2'b00) begin
        mem[a2] <= bus.mem_wdata[23:16];
        mem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    pre_addr = addr; pre_data = data; pre_we = 1'b1;
    @(negedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one request, waits for its accept edge, then scrambles the inputs.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [7:0] addr, input logic [31:0] wdata);
    bus.req_write = wr; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_size = 2'b01; bus.req_signed = ~sgn;
    bus.req_addr = 8'hAA; bus.req_wdata = 32'hDEADBEEF;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got %b want 1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    total++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobes got %b want 00", {bus.mem_read, bus.mem_write}); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got %h want 0", bus.resp_rdata); end
    total++; if (bus.mem_addr !== 8'h0) begin bad++; $display("[TB] FAIL reset_addr got %h want 0", bus.mem_addr); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw_aligned();
    poke(8'h00, 8'h11); poke(8'h01, 8'h00); poke(8'h02, 8'h00); poke(8'h03, 8'h00);
    issue(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    total++; if ({bus.mem_read, bus.mem_write, bus.mem_size, bus.mem_addr} !== {1'b1, 1'b0, 2'b00, 8'h00}) begin
      bad++; $display("[TB] FAIL lw_beat got rd=%b wr=%b sz=%b a=%h want 1 0 00 00", bus.mem_read, bus.mem_write, bus.mem_size, bus.mem_addr); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL lw_busy_ready got %b want 0", bus.req_ready); end
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h00000011) begin
      bad++; $display("[TB] FAIL lw_resp got v=%b d=%h want 1 00000011", bus.resp_valid, bus.resp_rdata); end
    total++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_done_ready got rdy=%b rd=%b want 1 0", bus.req_ready, bus.mem_read); end
    tick();
    total++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h00000011) begin
      bad++; $display("[TB] FAIL lw_hold got v=%b d=%h want 0 00000011", bus.resp_valid, bus.resp_rdata); end
  endtask

  task automatic test_size11();
    poke(8'h08, 8'h85);
    issue(1'b0, 2'b11, 1'b1, 8'h08, 32'h0);
    total++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h08) begin
      bad++; $display("[TB] FAIL size11_beat got rd=%b a=%h want 1 08", bus.mem_read, bus.mem_addr); end
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFFFF85) begin
      bad++; $display("[TB] FAIL size11_resp got v=%b d=%h want 1 ffffff85", bus.resp_valid, bus.resp_rdata); end
  endtask

  task automatic test_back_to_back();
    poke(8'h05, 8'h9C); poke(8'h06, 8'h34); poke(8'h07, 8'h92);
    issue(1'b0, 2'b10, 1'b1, 8'h05, 32'h0);
    bus.req_write = 1'b0; bus.req_size = 2'b01; bus.req_signed = 1'b1; bus.req_addr = 8'h06; bus.req_valid = 1'b1;
    total++; if (bus.mem_addr !== 8'h05 || bus.mem_size !== 2'b10) begin
      bad++; $display("[TB] FAIL b2b_first_beat got a=%h sz=%b want 05 10", bus.mem_addr, bus.mem_size); end
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFFFF9C || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_first_resp got v=%b d=%h rdy=%b want 1 ffffff9c 1", bus.resp_valid, bus.resp_rdata, bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h06 || bus.mem_size !== 2'b01 || bus.mem_signed !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_second_beat got rd=%b a=%h sz=%b sg=%b want 1 06 01 0", bus.mem_read, bus.mem_addr, bus.mem_size, bus.mem_signed); end
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFF9234) begin
      bad++; $display("[TB] FAIL b2b_second_resp got v=%b d=%h want 1 ffff9234", bus.resp_valid, bus.resp_rdata); end
  endtask

`ifndef MISALIGN_TRAP_EN
  task automatic test_lh_split(input logic sgn, input logic [31:0] expected);
    poke(8'h03, 8'h80); poke(8'h04, 8'hFF);
    issue(1'b0, 2'b01, sgn, 8'h03, 32'h0);
    total++; if (bus.mem_read !== 1'b1 || bus.mem_size !== 2'b10 || bus.mem_addr !== 8'h03) begin
      bad++; $display("[TB] FAIL lh_beat0 got rd=%b sz=%b a=%h want 1 10 03", bus.mem_read, bus.mem_size, bus.mem_addr); end
    tick();
    total++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h04 || bus.resp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL lh_beat1 got rd=%b a=%h v=%b want 1 04 0", bus.mem_read, bus.mem_addr, bus.resp_valid); end
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== expected || bus.resp_err !== 1'b0) begin
      bad++; $display("[TB] FAIL lh_resp got v=%b d=%h e=%b want 1 %h 0", bus.resp_valid, bus.resp_rdata, bus.resp_err, expected); end
  endtask

  task automatic test_sw_split();
    logic [7:0] exp_byte [4];
    int         beat_bad;
    exp_byte[0] = 8'hDD; exp_byte[1] = 8'hCC; exp_byte[2] = 8'hBB; exp_byte[3] = 8'hAA;
    beat_bad = 0;
    issue(1'b1, 2'b00, 1'b0, 8'h01, 32'hAABBCCDD);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 8'(1 + i) ||
          bus.mem_wdata !== {24'h0, exp_byte[i]} || bus.resp_valid !== 1'b0) begin
        bad++; beat_bad++;
        $display("[TB] FAIL sw_beat%0d got wr=%b a=%h d=%h v=%b want 1 %h %h 0", i, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.resp_valid, 8'(1 + i), {24'h0, exp_byte[i]});
      end
      tick();
    end
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.mem_write !== 1'b0) begin
      bad++; $display("[TB] FAIL sw_resp got v=%b d=%h wr=%b want 1 0 0", bus.resp_valid, bus.resp_rdata, bus.mem_write); end
    total++; if ({mem[4], mem[3], mem[2], mem[1]} !== 32'hAABBCCDD) begin
      bad++; $display("[TB] FAIL sw_memory got %h want aabbccdd", {mem[4], mem[3], mem[2], mem[1]}); end
  endtask

  task automatic test_lw_wrap();
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    poke(8'hFE, 8'h44); poke(8'hFF, 8'h33); poke(8'h00, 8'h22); poke(8'h01, 8'h11);
    issue(1'b0, 2'b00, 1'b1, 8'hFE, 32'h0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== exp_addr[i] || bus.mem_size !== 2'b10) begin
        bad++; $display("[TB] FAIL wrap_beat%0d got rd=%b a=%h sz=%b want 1 %h 10", i, bus.mem_read, bus.mem_addr, bus.mem_size, exp_addr[i]);
      end
      tick();
    end
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h11223344) begin
      bad++; $display("[TB] FAIL wrap_resp got v=%b d=%h want 1 11223344", bus.resp_valid, bus.resp_rdata); end
  endtask

  task automatic test_reset_mid_split();
    int stray;
    poke(8'h11, 8'h55); poke(8'h12, 8'h66); poke(8'h13, 8'h77);
    issue(1'b1, 2'b00, 1'b0, 8'h11, 32'h01020304);
    tick();
    total++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'h12) begin
      bad++; $display("[TB] FAIL rstmid_beat1 got wr=%b a=%h want 1 12", bus.mem_write, bus.mem_addr); end
    rst = 1'b1;
    #1;
    total++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_drop got wr=%b rd=%b want 0 0", bus.mem_write, bus.mem_read); end
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid !== 1'b0) stray++;
      tick();
    end
    total++; if (stray !== 0) begin bad++; $display("[TB] FAIL rstmid_no_resp got %0d pulses want 0", stray); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready got %b want 1", bus.req_ready); end
    total++; if ({mem[8'h13], mem[8'h12], mem[8'h11]} !== 24'h776604) begin
      bad++; $display("[TB] FAIL rstmid_memory got %h want 776604", {mem[8'h13], mem[8'h12], mem[8'h11]}); end
  endtask
`else
  task automatic test_trap(input logic [1:0] size, input logic [7:0] addr);
    int strobes;
    poke(addr, 8'h5A);
    strobes = 0;
    issue(1'b0, size, 1'b1, addr, 32'h0);
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) strobes++;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL trap_early_resp got %b want 0", bus.resp_valid); end
    tick();
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) strobes++;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL trap_resp got v=%b e=%b d=%h want 1 1 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
    total++; if (strobes !== 0) begin bad++; $display("[TB] FAIL trap_strobes got %0d active cycles want 0", strobes); end
    tick();
    total++; if (bus.resp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL trap_after got e=%b rdy=%b want 0 1", bus.resp_err, bus.req_ready); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_lw_aligned();
    test_size11();
    test_back_to_back();
`ifndef MISALIGN_TRAP_EN
    test_lh_split(1'b1, 32'hFFFFFF80);
    test_lh_split(1'b0, 32'h0000FF80);
    test_sw_split();
    test_lw_wrap();
    test_reset_mid_split();
`else
    test_trap(2'b01, 8'h01);
    test_trap(2'b00, 8'h02);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
